// File: rtl/chain_code_tx.sv
// chain_code_tx: buffers 4-bit chain codes and sends each as a start/4-data/stop frame.
// Build with CHAIN_TX_PARITY_EN defined to insert an even-parity bit before stop.
module chain_code_tx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         code_valid,
    input  logic [3:0]                   code_data,
    output logic                         code_ready,
    output logic                         output_serial_bit,
    output logic                         busy,
    output logic                         Packet_Sent,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         error,
    output logic                         done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] PRE  = 8'(CLKS_PER_BIT - 2);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef CHAIN_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  r_Clk_Count;
    logic [1:0]  r_Bit_Index;
    logic [3:0]  r_Shift;
    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic       push;
    logic       pop;
    logic       bad;
    logic       bit_end;
    logic [1:0] next_bit;

    assign bit_end    = (r_Clk_Count == LAST);
    assign next_bit   = r_Bit_Index + 2'd1;
    assign code_ready = (fifo_count != FULL);
    assign push       = code_valid && code_ready && (code_data <= 4'd8);
    assign bad        = code_valid && code_ready && (code_data > 4'd8);
    assign busy       = (state != IDLE) || (fifo_count != '0);

    // A pop happens both on leaving IDLE and on a back-to-back restart out of STOP.
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= code_data;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            r_Clk_Count       <= '0;
            r_Bit_Index       <= '0;
            r_Shift           <= '0;
            output_serial_bit <= 1'b1;
            Packet_Sent       <= 1'b0;
            error             <= 1'b0;
            done              <= 1'b0;
        end else begin
            Packet_Sent <= 1'b0;
            error       <= bad;
            unique case (state)
                IDLE: begin
                    r_Clk_Count <= '0;
                    if (pop) begin
                        r_Shift           <= mem[rd_ptr];
                        output_serial_bit <= 1'b0;
                        state             <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        r_Clk_Count       <= '0;
                        r_Bit_Index       <= '0;
                        output_serial_bit <= r_Shift[0];
                        state             <= DATA;
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        r_Clk_Count <= '0;
                        if (r_Bit_Index == 2'd3) begin
`ifdef CHAIN_TX_PARITY_EN
                            output_serial_bit <= ^r_Shift;
                            state             <= PARITY;
`else
                            output_serial_bit <= 1'b1;
                            state             <= STOP;
`endif
                        end else begin
                            r_Bit_Index       <= next_bit;
                            output_serial_bit <= r_Shift[next_bit];
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 8'd1;
                    end
                end
`ifdef CHAIN_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        r_Clk_Count       <= '0;
                        output_serial_bit <= 1'b1;
                        state             <= STOP;
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        r_Clk_Count <= '0;
                        if (pop) begin
                            r_Shift           <= mem[rd_ptr];
                            output_serial_bit <= 1'b0;
                            state             <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        r_Clk_Count <= r_Clk_Count + 8'd1;
                        // Registered one cycle early so the pulse lands in the final stop cycle.
                        if (r_Clk_Count == PRE) begin
                            Packet_Sent <= 1'b1;
                            if (r_Shift == 4'd8) done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chain_code_tx.sv
// Testbench for chain_code_tx: frame-timeline reference model with directed and random codes.
module tb_chain_code_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 8;
`ifdef CHAIN_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [3:0] code_data;
    logic       code_ready;
    logic       output_serial_bit;
    logic       busy;
    logic       Packet_Sent;
    logic [3:0] fifo_count;
    logic       error;
    logic       done;

    chain_code_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .reset(reset),
        .code_valid(code_valid),
        .code_data(code_data),
        .code_ready(code_ready),
        .output_serial_bit(output_serial_bit),
        .busy(busy),
        .Packet_Sent(Packet_Sent),
        .fifo_count(fifo_count),
        .error(error),
        .done(done)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Model: pending codes plus the frame currently on the line and its age in cycles.
    int         q[$];
    bit         active = 0;
    int         el = 0;
    logic [3:0] cur = '0;
    bit         done_m = 0;
    bit         err_m = 0;
    bit         ps_m = 0;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_line();
        int b;
        if (!active) return 1'b1;
        b = el / CPB;
        if (b == 0) return 1'b0;
        if (b <= 4) return cur[b-1];
        if (b == 5 && NB == 7) return ^cur;
        return 1'b1;
    endfunction

    task automatic check_all();
        check("line", {7'd0, output_serial_bit}, {7'd0, exp_line()});
        check("ready", {7'd0, code_ready}, {7'd0, q.size() != DEPTH});
        check("busy", {7'd0, busy}, {7'd0, active || q.size() != 0});
        check("count", {4'd0, fifo_count}, 8'(q.size()));
        check("sent", {7'd0, Packet_Sent}, {7'd0, ps_m});
        check("error", {7'd0, error}, {7'd0, err_m});
        check("done", {7'd0, done}, {7'd0, done_m});
    endtask

    task automatic tick(input logic v, input logic [3:0] d);
        bit acc;
        code_valid = v;
        code_data  = d;
        acc = v && (q.size() != DEPTH);
        @(posedge CLK);
        if (active) begin
            el++;
            if (el == NB * CPB) active = 0;
        end
        if (!active && q.size() != 0) begin
            cur = 4'(q.pop_front());
            active = 1;
            el = 0;
        end
        if (acc && d <= 4'd8) q.push_back(int'(d));
        err_m = acc && (d > 4'd8);
        ps_m  = active && (el == NB * CPB - 1);
        if (ps_m && cur == 4'd8) done_m = 1;
        #1;
        check_all();
        code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    task automatic model_clear();
        q.delete();
        active = 0;
        el = 0;
        done_m = 0;
        err_m = 0;
        ps_m = 0;
    endtask

    initial begin
        reset = 1'b1;
        code_valid = 1'b0;
        code_data = 4'd0;
        #3;
        check_all();
        @(negedge CLK);
        reset = 1'b0;
        idle(3);

        // Single frame carrying 4'b0010
        tick(1'b1, 4'b0010);
        idle(NB * CPB + 5);
        check("idle_after_frame", {7'd0, busy}, 8'd0);

        // Nine codes back-to-back, one more than the FIFO holds
        for (int i = 0; i < 9; i++) tick(1'b1, 4'(i));
        check("full_ready", {7'd0, code_ready}, 8'd0);
        idle(9 * NB * CPB + 10);

        // Illegal code is dropped with an error pulse
        tick(1'b1, 4'b1011);
        idle(5);

        // 0, 7, terminator
        tick(1'b1, 4'd0);
        tick(1'b1, 4'd7);
        tick(1'b1, 4'd8);
        idle(3 * NB * CPB + 10);
        check("done_sticky", {7'd0, done}, 8'd1);

`ifdef CHAIN_TX_PARITY_EN
        tick(1'b1, 4'b0111);
        idle(NB * CPB + 5);
`endif

        // Random traffic, including illegal codes and overflow attempts
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0)
                tick(1'b1, 4'($urandom_range(0, 15)));
            else
                tick(1'b0, 4'd0);
        end
        idle(DEPTH * NB * CPB + NB * CPB);

        // Reset in the middle of data bit 2 with three codes queued
        for (int i = 0; i < 4; i++) tick(1'b1, 4'(i + 3));
        for (int i = 0; i < 200 && !(active && el == 3 * CPB + 5); i++)
            tick(1'b0, 4'd0);
        check("pre_reset_queued", {4'd0, fifo_count}, 8'd3);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        @(negedge CLK);
        reset = 1'b0;
        idle(NB * CPB * 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chain_code_tx.md
# chain_code_tx

Serial transmitter feeding the chain-code decoder. It accepts 4-bit chain codes from the boundary-tracing logic over a valid/ready handshake and buffers them in a small FIFO. Each code goes out on a single serial line as a UART-style frame: start bit 0, four data bits LSB first, stop bit 1. The frame format and bit period match the decoder's receiver, so the two blocks link directly.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..255; must equal the decoder's value.
- FIFO_DEPTH, 8, code buffer entries; power of two, 2..64.
- CLK  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- code_valid  in  1  upstream presents a code.
- code_data  in  4  chain code: 0..7 are directions, 8 is the terminator, 9..15 are illegal.
- code_ready  out  1  high when FIFO not full; a code transfers when valid & ready at a rising edge.
- output_serial_bit  out  1  serial line, registered, idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- Packet_Sent  out  1  one-cycle pulse in the last cycle of each stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- error  out  1  one-cycle pulse when an illegal code (9..15) is offered with valid & ready; that code is dropped and not stored.
- done  out  1  sticky; set in the cycle Packet_Sent pulses for a frame carrying code 8.

## Operation
- Reset values:
  - output_serial_bit=1, code_ready=1.
  - busy=0, Packet_Sent=0, fifo_count=0, error=0, done=0.
  - FSM in IDLE, FIFO empty, clock counter and bit index 0.
- FIFO:
  - Write on valid & ready & legal code.
  - Read when the FSM leaves IDLE.
  - Write and read in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - code_ready = (fifo_count != FIFO_DEPTH); it is never high when full.
- FSM:
  - IDLE → START when the FIFO is non-empty. On that edge, pop into the shift register and drive the line to 0.
  - START (line 0) → DATA after CLKS_PER_BIT cycles.
  - DATA: drive shift bit [r_Bit_Index], indices 0..3, each for CLKS_PER_BIT cycles. After bit 3 → STOP, or → PARITY if configured.
  - STOP (line 1) lasts CLKS_PER_BIT cycles. Packet_Sent is high in its final cycle. Then → START directly if the FIFO is non-empty (back-to-back frames, no idle gap), else → IDLE.
- Clock counter: 8 bits, counts 0..CLKS_PER_BIT-1, resets to 0 on each bit boundary.
- done stays 1 after the terminator. Further codes are still accepted and transmitted. Only reset clears done.
- Reset mid-frame: line returns to 1 immediately (asynchronous), the frame is truncated and FIFO contents are lost. The downstream receiver resynchronises on the next start bit.

## Timing
- Latency: code accepted at edge k into an empty, idle block → line low from edge k+1.
- Frame length: 6×CLKS_PER_BIT cycles, or 7×CLKS_PER_BIT with parity.
- Data bit n occupies cycles [(1+n)×CLKS_PER_BIT, (2+n)×CLKS_PER_BIT) after the start edge.
- Back-to-back: the next start bit begins on the edge after the final stop cycle.
- Sustained throughput: one code per frame. The FIFO absorbs bursts up to FIFO_DEPTH codes, plus one code held in the shift register.
- error and Packet_Sent are single-cycle, registered pulses.

## Configuration
- CHAIN_TX_PARITY_EN defined:
  - Adds an even-parity bit (XOR of the 4 data bits) in state PARITY between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Frame becomes 7 bits; the receiver must be built with matching parity support.
- CHAIN_TX_PARITY_EN undefined:
  - PARITY state absent; 6-bit frame, directly compatible with the existing decoder.

## Test plan
- Reset, then push code 4'b0010 with CLKS_PER_BIT=10 → line low on the next edge, then bits 0,1,0,0 for 10 cycles each, then 1. Packet_Sent pulses at cycle 59 after the start edge; busy returns to 0 afterwards.
- Push 9 codes in 9 consecutive cycles with FIFO_DEPTH=8 → first code popped immediately, 8 buffered, code_ready low while fifo_count=8. All 9 frames go out back-to-back with no high gap between stop and the next start.
- Push code 4'b1011 → error pulses for 1 cycle, fifo_count stays 0, line stays high.
- Push 0, 7, 8 → three frames. done rises in the cycle Packet_Sent pulses for the third frame and stays high. Loopback into the decoder yields ChainCode_ouput 0, 7, 8 and its done=1.
- Assert reset in the middle of data bit 2 with 3 codes queued → output_serial_bit=1 and fifo_count=0 immediately, with no further frames after release.
- With CHAIN_TX_PARITY_EN, push 4'b0111 → parity bit 1 appears after data bit 3; frame length is 70 cycles.
